soc_event_queue: RTL

SOC_EVENT_QUEUE -- requirements
Module: soc_event_queue

---
 rtl/soc_event_queue.sv | 132 +++++++++++++
 1 files changed

// File: rtl/soc_event_queue.sv
// rtl/soc_event_queue.sv - Peripheral event capture, arbiter handshake and event-ID FIFO
//
// Purpose:
//   Captures single-cycle event pulses into a pending vector and presents that
//   vector to an external round-robin arbiter. Each accepted grant is encoded
//   to an event ID and pushed into a small FIFO. A downstream consumer pops the
//   FIFO with a valid/ready handshake. An event that arrives while its pending
//   bit is still set, and is not being cleared that cycle, is dropped. A dropped
//   event is reported by a registered one-cycle pulse on lost_o.
//
// Ports:
//   clk_i          in   1           clock, all state on the rising edge
//   rstn_i         in   1           asynchronous active-low reset
//   evt_i          in   EVNT_NUM    event pulses from peripherals
//   arb_req_o      out  EVNT_NUM    pending-event vector to the arbiter
//   arb_grant_i    in   EVNT_NUM    one-hot grant from the arbiter
//   arb_anygrant_i in   1           arbiter reports a grant
//   arb_ack_o      out  1           grant accepted (queue not full)
//   evt_valid_o    out  1           queue head valid
//   evt_data_o     out  EVNT_WIDTH  queue head event ID (0 when empty)
//   evt_ready_i    in   1           consumer pops the head
//   lost_o         out  EVNT_NUM    one-cycle pulse per dropped event

module soc_event_queue #(
    parameter int EVNT_NUM    = 256,
    parameter int QUEUE_DEPTH = 4,
    parameter int EVNT_WIDTH  = $clog2(EVNT_NUM)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [EVNT_NUM-1:0]   evt_i,
    output logic [EVNT_NUM-1:0]   arb_req_o,
    input  logic [EVNT_NUM-1:0]   arb_grant_i,
    input  logic                  arb_anygrant_i,
    output logic                  arb_ack_o,
    output logic                  evt_valid_o,
    output logic [EVNT_WIDTH-1:0] evt_data_o,
    input  logic                  evt_ready_i,
    output logic [EVNT_NUM-1:0]   lost_o
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [EVNT_NUM-1:0]   pend_q, pend_d;
    logic [EVNT_NUM-1:0]   lost_q, lost_d;
    logic [EVNT_NUM-1:0]   clr_vec;
    logic [EVNT_WIDTH-1:0] grant_idx;
    logic [EVNT_WIDTH-1:0] mem_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full;
    logic                  push;
    logic                  pop;

    // Lowest-index priority encoder: a malformed multi-hot grant still yields
    // exactly one ID, and only that ID's pending bit is cleared.
    always_comb begin
        grant_idx = '0;
        for (int i = EVNT_NUM - 1; i >= 0; i--) begin
            if (arb_grant_i[i]) begin
                grant_idx = EVNT_WIDTH'(i);
            end
        end
    end

    assign full      = (count_q == CNT_W'(QUEUE_DEPTH));
    // Ack is withheld while full even if the consumer pops this cycle; this
    // keeps the ack path free of any dependency on evt_ready_i.
    assign arb_ack_o = arb_anygrant_i & ~full;
    assign push      = arb_ack_o;
    assign pop       = evt_valid_o & evt_ready_i;

    always_comb begin
        clr_vec = '0;
        if (arb_ack_o && arb_grant_i[grant_idx]) begin
            clr_vec[grant_idx] = 1'b1;
        end
    end

    // A new pulse on a bit being cleared this cycle re-arms it rather than
    // being lost; only a pulse on a bit that stays pending is dropped.
    assign pend_d = (pend_q & ~clr_vec) | evt_i;
    assign lost_d = evt_i & pend_q & ~clr_vec;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pend_q   <= '0;
            lost_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pend_q   <= pend_d;
            lost_q   <= lost_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset: the pointers and count alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= grant_idx;
        end
    end

    assign arb_req_o   = pend_q;
    assign lost_o      = lost_q;
    assign evt_valid_o = (count_q != '0);
    assign evt_data_o  = evt_valid_o ? mem_q[rd_ptr_q] : '0;

endmodule
